// File: rtl/simple_alu_pkg.sv
// simple_alu_pkg: opcode encodings and legality check shared by the ALU files
package simple_alu_pkg;
  localparam logic [3:0] OP_AND    = 4'd0;
  localparam logic [3:0] OP_OR     = 4'd1;
  localparam logic [3:0] OP_XOR    = 4'd2;
  localparam logic [3:0] OP_NOT_A  = 4'd3;
  localparam logic [3:0] OP_NOT_B  = 4'd4;
  localparam logic [3:0] OP_ADD    = 4'd5;
  localparam logic [3:0] OP_SUB    = 4'd6;
  localparam logic [3:0] OP_PASS_A = 4'd7;
  localparam logic [3:0] OP_PASS_B = 4'd8;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_PASS_B;
  endfunction
endpackage

// File: rtl/simple_alu_core.sv
// simple_alu_core: combinational opcode decode producing result, carry/borrow and illegal flag
module simple_alu_core
  import simple_alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       sel_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             illegal_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  always_comb begin
    result_o = '0;
    case (sel_i)
      OP_AND:    result_o = a_i & b_i;
      OP_OR:     result_o = a_i | b_i;
      OP_XOR:    result_o = a_i ^ b_i;
      OP_NOT_A:  result_o = ~a_i;
      OP_NOT_B:  result_o = ~b_i;
      OP_ADD:    result_o = sum[WIDTH-1:0];
      OP_SUB:    result_o = diff[WIDTH-1:0];
      OP_PASS_A: result_o = a_i;
      OP_PASS_B: result_o = b_i;
      default:   result_o = '0;
    endcase
    carry_o   = (sel_i == OP_ADD) ? sum[WIDTH] : (sel_i == OP_SUB) ? diff[WIDTH] : 1'b0;
    illegal_o = !is_legal_op(sel_i);
  end
endmodule

// File: rtl/simple_alu.sv
// simple_alu: registered ALU with one-cycle latency, status flags and valid tracking
module simple_alu
  import simple_alu_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             illegal,
  output logic             out_valid
);
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_illegal;
  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q, zero_d, zero_q, illegal_d, illegal_q, valid_q;
  simple_alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a),
    .b_i      (b),
    .sel_i    (sel),
    .result_o (core_result),
    .carry_o  (core_carry),
    .illegal_o(core_illegal)
  );
  always_comb begin
    result_d  = in_valid ? core_result : result_q;
    carry_d   = in_valid ? core_carry : carry_q;
    zero_d    = in_valid ? (core_result == '0) : zero_q;
    illegal_d = in_valid ? core_illegal : illegal_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      valid_q   <= in_valid;
    end
  end
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_simple_alu.sv
// tb_simple_alu: directed checks of 1-bit and 8-bit ALU instances against hand-computed values
module tb_simple_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0;
  logic [3:0] s1 = 4'd0;
  logic       r1, c1, z1, il1, ov1;
  logic       iv8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00, r8;
  logic [3:0] s8 = 4'd0;
  logic       c8, z8, il8, ov8;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  simple_alu #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .sel(s1),
    .result(r1), .carry(c1), .zero(z1), .illegal(il1), .out_valid(ov1)
  );
  simple_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .sel(s8),
    .result(r8), .carry(c8), .zero(z8), .illegal(il8), .out_valid(ov8)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic r, input logic c, input logic z, input logic il, input logic ov);
    chk({tag, ".result"}, {63'd0, r1}, {63'd0, r});
    chk({tag, ".carry"}, {63'd0, c1}, {63'd0, c});
    chk({tag, ".zero"}, {63'd0, z1}, {63'd0, z});
    chk({tag, ".illegal"}, {63'd0, il1}, {63'd0, il});
    chk({tag, ".out_valid"}, {63'd0, ov1}, {63'd0, ov});
  endtask
  task automatic chk8(input string tag, input logic [7:0] r, input logic c, input logic z, input logic il, input logic ov);
    chk({tag, ".result"}, {56'd0, r8}, {56'd0, r});
    chk({tag, ".carry"}, {63'd0, c8}, {63'd0, c});
    chk({tag, ".zero"}, {63'd0, z8}, {63'd0, z});
    chk({tag, ".illegal"}, {63'd0, il8}, {63'd0, il});
    chk({tag, ".out_valid"}, {63'd0, ov8}, {63'd0, ov});
  endtask
  initial begin
    logic exp_r[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cyc();
    cyc();
    chk1("reset1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk8("reset8", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    iv1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s1 = 4'(i);
      cyc();
      chk1($sformatf("w1_a0b1_op%0d", i), exp_r[i], i == 6, !exp_r[i], 1'b0, 1'b1);
    end
    a1 = 1'b1; b1 = 1'b1; s1 = 4'd5;
    cyc();
    chk1("w1_add11", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    s1 = 4'd6;
    cyc();
    chk1("w1_sub11", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    a1 = 1'b1; b1 = 1'b0; s1 = 4'd9;
    cyc();
    chk1("w1_op9", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    s1 = 4'd15;
    cyc();
    chk1("w1_op15", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    iv1 = 1'b0;
    iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; s8 = 4'd0;
    cyc();
    chk8("w8_and", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    s8 = 4'd1;
    cyc();
    chk8("w8_or", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    s8 = 4'd5;
    cyc();
    chk8("w8_add", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    s8 = 4'd6;
    cyc();
    chk8("w8_sub", 8'hE1, 1'b0, 1'b0, 1'b0, 1'b1);
    a8 = 8'h0F; b8 = 8'hF0;
    cyc();
    chk8("w8_sub_swap", 8'h1F, 1'b1, 1'b0, 1'b0, 1'b1);
    a8 = 8'hFF; b8 = 8'h01; s8 = 4'd5;
    cyc();
    chk8("w8_add_wrap", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    a8 = 8'hA5; b8 = 8'h3C; s8 = 4'd15;
    cyc();
    chk8("w8_op15", 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    iv8 = 1'b0;
    rst = 1'b1; iv1 = 1'b1; s1 = 4'd1; a1 = 1'b1; b1 = 1'b1;
    cyc();
    chk1("rst_ovr_c1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk1("rst_ovr_c2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    cyc();
    chk1("rst_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    iv1 = 1'b0;
    iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; s8 = 4'd6;
    cyc();
    chk8("hold_capture", 8'hE1, 1'b0, 1'b0, 1'b0, 1'b1);
    iv8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'(i * 37); b8 = 8'(200 - i); s8 = 4'(i * 5 + 1);
      cyc();
      chk8($sformatf("hold_c%0d", i), 8'hE1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
